mem_1rw_req_ctrl: RTL and testbench

//  Initiator-side controller for a single-port 1RW RAM array instance. Arbitrates a write-request and a

---
 rtl/mem_1rw_req_ctrl_pkg.sv | 15 +
 rtl/mem_1rw_rsp_fifo.sv | 45 ++++
 rtl/mem_1rw_req_ctrl.sv | 109 ++++++++++
 tb/tb_mem_1rw_req_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_1rw_req_ctrl_pkg.sv
// Shared definitions for the 1RW RAM request controller: grant encodings and
// the RAM read-latency helper.
package mem_1rw_req_ctrl_pkg;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    // A registered RAM output adds one cycle to the read latency.
    function automatic int mem_rd_lat(input bit dout_reg);
        return dout_reg ? 2 : 1;
    endfunction

endpackage

// File: rtl/mem_1rw_rsp_fifo.sv
// First-word-fall-through register FIFO that buffers RAM read data until the
// consumer takes it. Pointers carry one extra wrap bit to tell full from empty.
module mem_1rw_rsp_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH_DATA-1:0] push_data,
    input  logic                  pop,
    output logic [WIDTH_DATA-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic [WIDTH_DATA-1:0] data_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only visible once its pointer passes it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
                data_reg[gi] <= push_data;
        end
    end

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_data = empty ? '0 : data_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/mem_1rw_req_ctrl.sv
// Arbitrates write and read request channels onto one 1RW RAM port, tracks the
// RAM read latency, and returns read data in order through a credited buffer.
module mem_1rw_req_ctrl
    import mem_1rw_req_ctrl_pkg::*;
#(
    parameter int    WIDTH_DATA = 8,
    parameter int    WIDTH_ADDR = 8,
    parameter string DOUT_REG   = "false",
    parameter int    RSP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [WIDTH_ADDR-1:0]         wr_req_addr,
    input  logic [WIDTH_DATA-1:0]         wr_req_data,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [WIDTH_ADDR-1:0]         rd_req_addr,
    output logic                          rd_rsp_valid,
    input  logic                          rd_rsp_ready,
    output logic [WIDTH_DATA-1:0]         rd_rsp_data,
    output logic [WIDTH_ADDR-1:0]         mem_addr,
    output logic                          mem_wen,
    output logic [WIDTH_DATA-1:0]         mem_din,
    output logic                          mem_ren,
    input  logic [WIDTH_DATA-1:0]         mem_dout,
    output logic [$clog2(RSP_DEPTH):0]    rd_inflight
);
    localparam int RD_LAT = mem_rd_lat(DOUT_REG == "true");
    localparam int CW     = $clog2(RSP_DEPTH) + 1;

    if ((RSP_DEPTH < RD_LAT + 1) || ((RSP_DEPTH & (RSP_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("RSP_DEPTH must be a power of 2 and at least read latency + 1");
    end

    grant_e                last_grant_reg, last_grant_next;
    logic [CW-1:0]         inflight_reg, inflight_next;
    logic [RD_LAT-1:0]     pipe_reg, pipe_next;
    logic [WIDTH_ADDR-1:0] addr_hold_reg;
    logic [WIDTH_DATA-1:0] din_hold_reg;

    logic credit_ok, wr_win, rd_win, wr_acc, rd_acc;
    logic rsp_push, rsp_pop, rsp_full, rsp_empty;

    assign credit_ok = (inflight_reg < CW'(RSP_DEPTH));

    always_comb begin
        wr_win          = wr_req_valid &
                          (~rd_req_valid | ~credit_ok | (last_grant_reg == GRANT_RD));
        rd_win          = rd_req_valid & credit_ok & ~wr_win;
        wr_req_ready    = ~rst & ~rd_win;
        rd_req_ready    = ~rst & credit_ok & ~wr_win;
        wr_acc          = wr_req_valid & wr_req_ready;
        rd_acc          = rd_req_valid & rd_req_ready;
        last_grant_next = last_grant_reg;
        if (wr_acc)      last_grant_next = GRANT_WR;
        else if (rd_acc) last_grant_next = GRANT_RD;
        mem_wen  = wr_acc;
        mem_ren  = rd_acc;
        mem_addr = addr_hold_reg;
        if (wr_acc)      mem_addr = wr_req_addr;
        else if (rd_acc) mem_addr = rd_req_addr;
        mem_din  = wr_acc ? wr_req_data : din_hold_reg;
    end

    // Bit 0 marks a read issued this cycle; the top bit lines up with valid mem_dout.
    assign pipe_next[0] = rd_acc;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        assign pipe_next[gi] = pipe_reg[gi-1];
    end

    assign rsp_pop       = rd_rsp_valid & rd_rsp_ready;
    assign rsp_push      = pipe_reg[RD_LAT-1] & (~rsp_full | rsp_pop);
    assign inflight_next = inflight_reg + CW'(rd_acc) - CW'(rsp_pop);
    assign rd_rsp_valid  = ~rsp_empty;
    assign rd_inflight   = inflight_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= GRANT_RD;
            inflight_reg   <= '0;
            pipe_reg       <= '0;
            addr_hold_reg  <= '0;
            din_hold_reg   <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            inflight_reg   <= inflight_next;
            pipe_reg       <= pipe_next;
            addr_hold_reg  <= mem_addr;
            din_hold_reg   <= mem_din;
        end
    end

    mem_1rw_rsp_fifo #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (mem_dout),
        .pop       (rsp_pop),
        .pop_data  (rd_rsp_data),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

endmodule

// File: tb/tb_mem_1rw_req_ctrl.sv
// Directed bench for mem_1rw_req_ctrl driving a behavioural 1RW RAM with the
// matching read latency.
module tb_mem_1rw_req_ctrl;
    parameter string DOUT_REG  = "false";
    localparam int   RSP_DEPTH = 4;
    localparam int   L         = (DOUT_REG == "true") ? 2 : 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req_valid, wr_req_ready;
    logic [7:0] wr_req_addr, wr_req_data;
    logic       rd_req_valid, rd_req_ready;
    logic [7:0] rd_req_addr;
    logic       rd_rsp_valid, rd_rsp_ready;
    logic [7:0] rd_rsp_data;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       mem_wen, mem_ren;
    logic [2:0] rd_inflight;

    logic [7:0] ram [256];
    logic [7:0] ram_q1, ram_q2;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_din;
        if (mem_ren) ram_q1 <= ram[mem_addr];
        ram_q2 <= ram_q1;
    end
    assign mem_dout = (L == 2) ? ram_q2 : ram_q1;

    mem_1rw_req_ctrl #(
        .WIDTH_DATA (8),
        .WIDTH_ADDR (8),
        .DOUT_REG   (DOUT_REG),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_din      (mem_din),
        .mem_ren      (mem_ren),
        .mem_dout     (mem_dout),
        .rd_inflight  (rd_inflight)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the current (settled) cycle, score any popped response, then advance.
    task automatic step();
        logic [7:0] e;
        chk("excl", 32'(mem_wen & mem_ren), 0);
        if (rd_rsp_valid && rd_rsp_ready) begin
            chk("rsp_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rd_rsp_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int g = 0; g < 40 && exp_q.size() != 0; g++) begin
            #1;
            step();
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int wi, ri;
        rst = 1'b1;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_wr_rdy", 32'(wr_req_ready), 0);
        chk("rst_rd_rdy", 32'(rd_req_ready), 0);
        chk("rst_rsp_vld", 32'(rd_rsp_valid), 0);
        chk("rst_infl", 32'(rd_inflight), 0);
        chk("rst_mem", {mem_addr, mem_din, 6'b0, mem_wen, mem_ren}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_wr_rdy", 32'(wr_req_ready), 1);
        chk("idle_rd_rdy", 32'(rd_req_ready), 1);

        // 1: write 0xA5@0x10, read it back next cycle, measure response latency
        wr_req_valid = 1'b1; wr_req_addr = 8'h10; wr_req_data = 8'hA5;
        #1;
        chk("t1_wen", 32'(mem_wen), 1);
        chk("t1_waddr", 32'(mem_addr), 32'h10);
        chk("t1_din", 32'(mem_din), 32'hA5);
        step();
        wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 8'h10;
        #1;
        chk("t1_ren", 32'(mem_ren), 1);
        chk("t1_rd_rdy", 32'(rd_req_ready), 1);
        step();
        rd_req_valid = 1'b0;
        #1;
        chk("t1_infl", 32'(rd_inflight), 1);
        lat = 0;
        while (!rd_rsp_valid && lat < 6) begin
            step();
            #1;
            lat++;
        end
        chk("t1_lat", lat, L);
        chk("t1_data", 32'(rd_rsp_data), 32'hA5);
        chk("t1_idle", {mem_addr, mem_din, 6'b0, mem_wen, mem_ren}, {8'h10, 8'hA5, 8'h0});
        exp_q.push_back(8'hA5);
        rd_rsp_ready = 1'b1;
        step();
        #1;
        chk("t1_empty", 32'(rd_rsp_valid), 0);
        chk("t1_infl0", 32'(rd_inflight), 0);

        // 2: both channels valid every cycle -> W,R,W,R...
        wi = 0; ri = 0;
        for (int c = 0; c < 16; c++) begin
            wr_req_valid = (wi < 8); wr_req_addr = 8'(8'h30 + wi); wr_req_data = 8'(8'hC0 + wi);
            rd_req_valid = (ri < 8); rd_req_addr = 8'(8'h30 + ri);
            #1;
            chk("t2_wen", 32'(mem_wen), 32'((c % 2) == 0));
            chk("t2_ren", 32'(mem_ren), 32'((c % 2) == 1));
            if ((c % 2) == 0) wi++;
            else begin
                exp_q.push_back(8'(8'hC0 + ri));
                ri++;
            end
            step();
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        drain("t2_drain");

        // 3: preload 0..7, then fill credit with the consumer stalled
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_req_valid = 1'b1; wr_req_addr = 8'(i); wr_req_data = 8'(i);
            #1;
            step();
        end
        wr_req_valid = 1'b0;
        ri = 0;
        for (int c = 0; c < 6; c++) begin
            rd_req_valid = 1'b1; rd_req_addr = 8'(ri);
            #1;
            chk("t3_rd_rdy", 32'(rd_req_ready), 32'(c < RSP_DEPTH));
            if (c < RSP_DEPTH) begin
                exp_q.push_back(8'(ri));
                ri++;
            end
            step();
        end
        rd_req_addr = 8'(ri);
        #1;
        chk("t3_infl_full", 32'(rd_inflight), RSP_DEPTH);
        chk("t3_rdy_blk", 32'(rd_req_ready), 0);
        chk("t3_rsp_vld", 32'(rd_rsp_valid), 1);
        rd_rsp_ready = 1'b1;
        step();

        // 4: pop and accept in the same cycle keep the credit count steady
        #1;
        chk("t4_infl", 32'(rd_inflight), RSP_DEPTH - 1);
        chk("t4_rd_rdy", 32'(rd_req_ready), 1);
        chk("t4_rsp_vld", 32'(rd_rsp_valid), 1);
        exp_q.push_back(8'(ri));
        ri++;
        step();
        rd_req_addr = 8'(ri);
        #1;
        chk("t4_hold", 32'(rd_inflight), RSP_DEPTH - 1);
        for (int g = 0; g < 40 && (ri < 8 || exp_q.size() != 0); g++) begin
            rd_req_valid = (ri < 8); rd_req_addr = 8'(ri);
            #1;
            if (rd_req_valid && rd_req_ready) begin
                exp_q.push_back(8'(ri));
                ri++;
            end
            step();
        end
        rd_req_valid = 1'b0;
        chk("t3_issued", ri, 8);
        chk("t3_drain", exp_q.size(), 0);
        #1; step(); #1;
        chk("t3_no_dup", 32'(rd_rsp_valid), 0);
        chk("t3_infl0", 32'(rd_inflight), 0);

        // 5: reset while reads are in flight and buffered
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_req_valid = 1'b1; rd_req_addr = 8'(i);
            #1;
            step();
        end
        rd_req_addr = 8'h03;
        rst = 1'b1;
        #1;
        chk("t5_rsp_vld", 32'(rd_rsp_valid), 0);
        chk("t5_rsp_data", 32'(rd_rsp_data), 0);
        chk("t5_infl", 32'(rd_inflight), 0);
        chk("t5_rdy", {30'b0, wr_req_ready, rd_req_ready}, 0);
        chk("t5_mem", {mem_addr, mem_din, 6'b0, mem_wen, mem_ren}, 0);
        step(); step();
        rd_req_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_stale", 32'(rd_rsp_valid), 0);
            step();
        end
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1; rd_req_addr = 8'h03;
        exp_q.push_back(8'h03);
        #1;
        step();
        rd_req_valid = 1'b0;
        drain("t5_drain");

        // 6: read before a write to the same address sees old data, after sees new
        wr_req_valid = 1'b1; wr_req_addr = 8'h20; wr_req_data = 8'h11;
        #1; step();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 8'h20;
        exp_q.push_back(8'h11);
        #1;
        chk("t6_ren", 32'(mem_ren), 1);
        step();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b1; wr_req_data = 8'h5A;
        #1;
        chk("t6_wen", 32'(mem_wen), 1);
        step();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1;
        exp_q.push_back(8'h5A);
        #1;
        step();
        rd_req_valid = 1'b0;
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
